smm_ctrl: RTL and testbench

Sequencer for the two-level Strassen matrix-multiply datapath. It accepts one 4x4 operand pair per transaction over a valid/ready handshake and registers the operands onto the datapath buses. It drives the datapath `load` and `sel` controls for the required number of cycles, waits the fixed pipeline latency, and captures the result. The result is held on a valid/ready output port until it is consumed. It sits between the accelerator's request interface and the multiplier; one transaction is in flight at a time.

---
 rtl/smm_pkg.sv | 20 ++
 rtl/smm_ctrl.sv | 111 +++++++++++
 tb/tb_smm_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/smm_pkg.sv
// rtl/smm_pkg.sv - shared types and defaults for the Strassen matrix-multiply controller and datapath wrappers
package smm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_BUSWIDTH  = DEF_DATAWIDTH * 16;

  localparam logic MODE_FULL    = 1'b0;
  localparam logic MODE_REDUCED = 1'b1;

  // Wide enough for LOAD_CYCLES-1 (max 6) and LATENCY-1 (max 14)
  localparam int CNT_W = 4;

endpackage

// File: rtl/smm_ctrl.sv
// rtl/smm_ctrl.sv - one-at-a-time sequencer: accept operands, pulse load, wait pipeline latency, hold result
module smm_ctrl
  import smm_pkg::*;
#(
  parameter int DATAWIDTH   = DEF_DATAWIDTH,
  parameter int BUSWIDTH    = DATAWIDTH * 16,
  parameter int LOAD_CYCLES = 2,
  parameter int LATENCY     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUSWIDTH-1:0] in_a,
  input  logic [BUSWIDTH-1:0] in_b,
  input  logic                in_mode,
  output logic [BUSWIDTH-1:0] smm_a,
  output logic [BUSWIDTH-1:0] smm_b,
  output logic                smm_load,
  output logic                smm_sel,
  input  logic [BUSWIDTH-1:0] smm_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUSWIDTH-1:0] out_data,
  output logic                busy,
  output logic [15:0]         op_count
);

  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_INIT  = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             capture;
  logic             retire;

  assign accept  = (state == IDLE) && in_valid && in_ready;
  assign capture = (state == WAIT) && (cnt == '0);
  assign retire  = (state == HOLD) && out_ready;

  assign smm_load  = (state == ISSUE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
          cnt_next   = LOAD_INIT;
        end
      end
      ISSUE: begin
        if (cnt == '0) begin
          state_next = WAIT;
          cnt_next   = LAT_INIT;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_ready is registered so it stays low through the reset cycle and rises one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      smm_a    <= '0;
      smm_b    <= '0;
      smm_sel  <= MODE_FULL;
      out_data <= '0;
      op_count <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      in_ready <= (state_next == IDLE);
      if (accept) begin
        smm_a   <= in_a;
        smm_b   <= in_b;
        smm_sel <= in_mode;
      end
      if (capture) begin
        out_data <= smm_c;
      end
      if (retire) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_smm_ctrl.sv
// tb/tb_smm_ctrl.sv - randomized self-checking bench for smm_ctrl (default and minimal-latency instances)
module tb_smm_ctrl;
  import smm_pkg::*;

  localparam int BW = DEF_BUSWIDTH;
  localparam int L0 = 2;
  localparam int T0 = 4;
  localparam int L1 = 1;
  localparam int T1 = 1;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, in_mode;
  logic [BW-1:0] in_a, in_b, smm_a, smm_b, smm_c, out_data;
  logic          smm_load, smm_sel, out_valid, out_ready, busy;
  logic [15:0]   op_count;

  logic          f_in_valid, f_in_ready, f_in_mode;
  logic [BW-1:0] f_in_a, f_in_b, f_smm_a, f_smm_b, f_smm_c, f_out_data;
  logic          f_smm_load, f_smm_sel, f_out_valid, f_out_ready, f_busy;
  logic [15:0]   f_op_count;

  int            total;
  int            passed;
  logic [15:0]   exp_count;
  logic [15:0]   f_exp_count;

  smm_ctrl #(.LOAD_CYCLES(L0), .LATENCY(T0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .smm_a(smm_a), .smm_b(smm_b), .smm_load(smm_load), .smm_sel(smm_sel),
    .smm_c(smm_c), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .op_count(op_count)
  );

  smm_ctrl #(.LOAD_CYCLES(L1), .LATENCY(T1)) dut_fast (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_a(f_in_a), .in_b(f_in_b),
    .in_mode(f_in_mode), .smm_a(f_smm_a), .smm_b(f_smm_b), .smm_load(f_smm_load), .smm_sel(f_smm_sel),
    .smm_c(f_smm_c), .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
    .busy(f_busy), .op_count(f_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One transaction on the default instance; capture expected on edge E(L0+T0)
  task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic mode,
                        input int stall, input logic [BW-1:0] res, input bit toggle);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL op_in_ready_idle got %b want 1", in_ready); else passed++;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; out_ready = 1'b0;
    for (int k = 1; k <= L0 + T0; k++) begin
      @(negedge clk);
      total++; if (smm_load !== (k <= L0)) $display("FAIL op_load k=%0d got %b want %b", k, smm_load, (k <= L0)); else passed++;
      total++; if (smm_a !== a || smm_b !== b) $display("FAIL op_operand_hold k=%0d got a=%h want a=%h", k, smm_a[31:0], a[31:0]); else passed++;
      total++; if (smm_sel !== mode) $display("FAIL op_sel_hold k=%0d got %b want %b", k, smm_sel, mode); else passed++;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL op_flags k=%0d got ov=%b ir=%b busy=%b want 0 0 1", k, out_valid, in_ready, busy); else passed++;
      smm_c = (k == L0 + T0) ? res : rnd_bus();
      if (toggle) begin
        in_valid = 1'($urandom); in_mode = ~in_mode; in_a = rnd_bus(); in_b = rnd_bus();
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    smm_c = rnd_bus(); in_valid = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold_flags s=%0d got ov=%b ir=%b want 1 0", s, out_valid, in_ready); else passed++;
      total++; if (out_data !== res) $display("FAIL hold_data s=%0d got %h want %h", s, out_data[31:0], res[31:0]); else passed++;
      total++; if (smm_sel !== mode || smm_a !== a || smm_b !== b) $display("FAIL hold_operands s=%0d got sel=%b want %b", s, smm_sel, mode); else passed++;
      if (toggle) begin in_mode = ~in_mode; in_valid = 1'($urandom); in_a = rnd_bus(); end
      out_ready = (s == stall);
      @(negedge clk);
      in_valid = 1'b0;
    end
    exp_count = exp_count + 16'd1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL retire_flags got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy); else passed++;
    total++; if (op_count !== exp_count) $display("FAIL op_count got %0d want %0d", op_count, exp_count); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_a = rnd_bus(); in_b = rnd_bus(); in_mode = 1'($urandom); smm_c = rnd_bus();
    end
    total++; if (in_ready !== 1'b0 || f_in_ready !== 1'b0) $display("FAIL reset_in_ready got %b/%b want 0", in_ready, f_in_ready); else passed++;
    total++; if (smm_a !== '0 || smm_b !== '0 || out_data !== '0) $display("FAIL reset_buses got a=%h d=%h want 0", smm_a[31:0], out_data[31:0]); else passed++;
    total++; if (smm_load !== 1'b0 || smm_sel !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctrl got ld=%b sel=%b ov=%b busy=%b want 0", smm_load, smm_sel, out_valid, busy); else passed++;
    total++; if (op_count !== 16'd0 || f_op_count !== 16'd0) $display("FAIL reset_count got %0d want 0", op_count); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || f_in_ready !== 1'b1) $display("FAIL release_in_ready got %b/%b want 1", in_ready, f_in_ready); else passed++;
    exp_count = 16'd0; f_exp_count = 16'd0;
  endtask

  task automatic test_single_full();
    run_op({16{32'h1111_1111}}, {16{32'h2222_2222}}, MODE_FULL, 0, {16{32'hC0FF_EE00}}, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(rnd_bus(), rnd_bus(), MODE_FULL, 10, rnd_bus(), 1'b0);
  endtask

  task automatic test_mode_hold();
    run_op(rnd_bus(), rnd_bus(), MODE_REDUCED, 3, rnd_bus(), 1'b1);
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 6; i++)
      run_op(rnd_bus(), rnd_bus(), 1'($urandom), $urandom_range(0, 4), rnd_bus(), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    int   last_rise;
    int   rises;
    logic prev_load;
    int   w;
    last_rise = -1; rises = 0; prev_load = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_a = rnd_bus(); in_b = rnd_bus(); in_mode = MODE_FULL;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      smm_c = rnd_bus();
      total++; if (in_ready && out_valid) $display("FAIL b2b_overlap c=%0d got ir=1 ov=1 want not both", c); else passed++;
      if (smm_load && !prev_load) begin
        if (rises > 0) begin
          total++; if (c - last_rise != L0 + T0 + 2) $display("FAIL b2b_spacing got %0d want %0d", c - last_rise, L0 + T0 + 2); else passed++;
        end
        last_rise = c; rises++;
      end
      prev_load = smm_load;
    end
    in_valid = 1'b0;
    w = 0;
    while (busy && w < 20) begin @(negedge clk); w++; end
    total++; if (busy !== 1'b0) $display("FAIL b2b_drain_timeout got busy=%b want 0", busy); else passed++;
    total++; if (rises != 6) $display("FAIL b2b_count got %0d want 6", rises); else passed++;
    exp_count = exp_count + 16'd6;
    out_ready = 1'b0;
    total++; if (op_count !== exp_count) $display("FAIL b2b_op_count got %0d want %0d", op_count, exp_count); else passed++;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    in_valid = 1'b1; in_a = rnd_bus(); in_b = rnd_bus(); in_mode = MODE_REDUCED;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (smm_load !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_ctrl got ld=%b ov=%b busy=%b want 0", smm_load, out_valid, busy); else passed++;
    total++; if (op_count !== 16'd0 || smm_a !== '0) $display("FAIL midrst_clear got cnt=%0d want 0", op_count); else passed++;
    rst = 1'b0; exp_count = 16'd0; f_exp_count = 16'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      smm_c = rnd_bus();
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_no_valid i=%0d got %b want 0", i, out_valid); else passed++;
    end
    run_op(rnd_bus(), rnd_bus(), MODE_FULL, 1, rnd_bus(), 1'b0);
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    exp_count = 16'hFFFF;
    run_op(rnd_bus(), rnd_bus(), MODE_FULL, 0, rnd_bus(), 1'b0);
    total++; if (op_count !== 16'h0000) $display("FAIL wrap got %h want 0000", op_count); else passed++;
  endtask

  task automatic test_min_params();
    logic [BW-1:0] a, b, res;
    for (int n = 0; n < 3; n++) begin
      a = rnd_bus(); b = rnd_bus(); res = rnd_bus();
      @(negedge clk);
      total++; if (f_in_ready !== 1'b1) $display("FAIL fast_in_ready got %b want 1", f_in_ready); else passed++;
      f_in_valid = 1'b1; f_in_a = a; f_in_b = b; f_in_mode = 1'(n); f_out_ready = 1'b0;
      for (int k = 1; k <= L1 + T1; k++) begin
        @(negedge clk);
        f_in_valid = 1'b0;
        total++; if (f_smm_load !== (k <= L1)) $display("FAIL fast_load k=%0d got %b want %b", k, f_smm_load, (k <= L1)); else passed++;
        total++; if (f_out_valid !== 1'b0 || f_smm_sel !== 1'(n)) $display("FAIL fast_wait k=%0d got ov=%b sel=%b", k, f_out_valid, f_smm_sel); else passed++;
        f_smm_c = (k == L1 + T1) ? res : rnd_bus();
      end
      @(negedge clk);
      f_smm_c = rnd_bus();
      total++; if (f_out_valid !== 1'b1 || f_out_data !== res) $display("FAIL fast_capture got ov=%b d=%h want 1 %h", f_out_valid, f_out_data[31:0], res[31:0]); else passed++;
      f_out_ready = 1'b1;
      @(negedge clk);
      f_out_ready = 1'b0;
      f_exp_count = f_exp_count + 16'd1;
      total++; if (f_op_count !== f_exp_count || f_out_valid !== 1'b0) $display("FAIL fast_count got %0d want %0d", f_op_count, f_exp_count); else passed++;
    end
  endtask

  initial begin
    total = 0; passed = 0; exp_count = 16'd0; f_exp_count = 16'd0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; smm_c = '0; out_ready = 1'b0;
    f_in_valid = 1'b0; f_in_a = '0; f_in_b = '0; f_in_mode = 1'b0; f_smm_c = '0; f_out_ready = 1'b0;
    test_reset();
    test_single_full();
    test_backpressure();
    test_mode_hold();
    test_random_ops();
    test_back_to_back();
    test_reset_midop();
    test_count_wrap();
    test_min_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
